uart_baud_gen: RTL and testbench

//  Runtime-programmable UART bit-timing generator with oversampling and an optional fractional divider.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_frac_div.sv | 64 ++++++
 rtl/uart_baud_gen.sv | 144 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bit-timing generator.
//   uart_state_e  : frame FSM encoding (ST_IDLE, ST_RUN)
//   FRAME_BITS_W  : width of the bits-per-frame and bit-index fields
//   baud_div()    : reset divisor for a clock/baud/oversample triple; the
//                   fraction is returned left-aligned in 32 bits so callers
//                   keep the top FRAC_W bits.
package uart_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } uart_state_e;

  localparam int unsigned FRAME_BITS_W = 4;

  typedef struct packed {
    logic [31:0] div_int;   // whole clk cycles per oversample tick
    logic [31:0] div_frac;  // remainder as a 0.32 binary fraction
  } baud_div_t;

  function automatic baud_div_t baud_div(input longint unsigned clk_freq,
                                         input longint unsigned baud,
                                         input longint unsigned os);
    longint unsigned den;
    longint unsigned rem;
    baud_div_t       res;
    den          = baud * os;
    res.div_int  = 32'(clk_freq / den);
    rem          = clk_freq % den;
    res.div_frac = 32'((rem << 32) / den);
    return res;
  endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Oversample tick divider with optional fractional accumulator.
// Build option: UART_BAUD_FRAC_EN adds the accumulator; without it the
// fraction input is ignored and every tick period equals the clamped div_int.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   en          count while high (frame running)
//   clr         restart counter and accumulator (frame start)
//   div_int     integer clk cycles per tick (values below 2 act as 2)
//   div_frac    fractional part, units of 1/2^FRAC_W clk
//   tick        one-cycle pulse on the last cycle of each tick period
module uart_frac_div #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   period;

  assign div_eff = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac};
  // Overflow at the previous tick stretches the current period by one clk.
  assign period  = {1'b0, div_eff} + {{DIV_W{1'b0}}, carry_q};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (tick) begin
      acc_q   <= acc_sum[FRAC_W-1:0];
      carry_q <= acc_sum[FRAC_W];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign period      = {1'b0, div_eff};
`endif

  assign tick = en && ({1'b0, div_cnt_q} == period - (DIV_W + 1)'(1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      div_cnt_q <= '0;
    end else if (en) begin
      div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-programmable UART bit-timing generator: oversample ticks plus
// per-bit start and mid-bit strobes for one frame of 1..MAX_BITS bits.
// Build option: UART_BAUD_FRAC_EN enables the fractional divider.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_div_int, cfg_div_frac  divisor; latched on cfg_load (deferred to the
//   cfg_load                   end of the frame while busy)
//   frame_bits, start          start a frame of frame_bits bits (idle only)
//   abort                      end the current frame without frame_done
//   busy                       frame in progress
//   tick_os                    oversample tick pulse
//   bit_start, bit_mid         first cycle of a bit / mid-bit sample pulse
//   bit_idx                    current bit index, held after the frame
//   frame_done                 normal frame completion pulse
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 200_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned MAX_BITS     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIV_W-1:0]        cfg_div_int,
  input  logic [FRAC_W-1:0]       cfg_div_frac,
  input  logic                    cfg_load,
  input  logic [FRAME_BITS_W-1:0] frame_bits,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    tick_os,
  output logic                    bit_start,
  output logic                    bit_mid,
  output logic [FRAME_BITS_W-1:0] bit_idx,
  output logic                    frame_done
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam baud_div_t RST_DIV = baud_div(64'(CLK_FREQ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  RST_INT  = RST_DIV.div_int[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] RST_FRAC = RST_DIV.div_frac[31 -: FRAC_W];

  uart_state_e             state_q;
  logic [DIV_W-1:0]        div_int_q, pend_int_q;
  logic [FRAC_W-1:0]       div_frac_q, pend_frac_q;
  logic                    pend_q;
  logic [OS_W-1:0]         os_cnt_q;
  logic [FRAME_BITS_W-1:0] bit_idx_q, nbits_q;
  logic                    bit_start_q, frame_done_q;
  logic                    tick, start_ok, launch, bit_end, frame_end;

  assign start_ok  = start && !abort && (frame_bits != '0) && (32'(frame_bits) <= MAX_BITS);
  assign launch    = (state_q == ST_IDLE) && start_ok;
  assign bit_end   = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign frame_end = bit_end && (bit_idx_q == nbits_q - FRAME_BITS_W'(1));

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == ST_RUN),
    .clr      (launch),
    .div_int  (div_int_q),
    .div_frac (div_frac_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      os_cnt_q <= '0;
    end else if (tick) begin
      os_cnt_q <= bit_end ? '0 : os_cnt_q + OS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_int_q    <= RST_INT;
      div_frac_q   <= RST_FRAC;
      pend_q       <= 1'b0;
      pend_int_q   <= '0;
      pend_frac_q  <= '0;
      bit_idx_q    <= '0;
      nbits_q      <= '0;
      bit_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bit_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_load) begin
            div_int_q  <= cfg_div_int;
            div_frac_q <= cfg_div_frac;
          end
          if (start_ok) begin
            state_q     <= ST_RUN;
            nbits_q     <= frame_bits;
            bit_idx_q   <= '0;
            bit_start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cfg_load) begin
            pend_q      <= 1'b1;
            pend_int_q  <= cfg_div_int;
            pend_frac_q <= cfg_div_frac;
          end
          if (abort || frame_end) begin
            state_q      <= ST_IDLE;
            frame_done_q <= !abort;
            // Staged divisor lands as the frame closes; a same-cycle load is newest.
            if (cfg_load) begin
              div_int_q  <= cfg_div_int;
              div_frac_q <= cfg_div_frac;
            end else if (pend_q) begin
              div_int_q  <= pend_int_q;
              div_frac_q <= pend_frac_q;
            end
            pend_q <= 1'b0;
          end else if (bit_end) begin
            bit_idx_q   <= bit_idx_q + FRAME_BITS_W'(1);
            bit_start_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign tick_os    = tick;
  assign bit_mid    = tick && (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
  assign bit_start  = bit_start_q;
  assign bit_idx    = bit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen. A behavioural model derives tick
// times in closed form (tick n of a frame ends at n*D + floor((n-1)*F/16) - 1
// clk after C0) and is compared with the DUT on every cycle; directed frames
// add literal timing expectations.
module tb_uart_baud_gen;

  localparam int OS       = 16;
  localparam int MAXB     = 12;
  localparam int FRAC_DEN = 16;
  localparam int RST_INT  = 200_000_000 / (9600 * 16);
  localparam int RST_FRAC = ((200_000_000 % (9600 * 16)) * 16) / (9600 * 16);
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cfg_load, start, abort;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac, frame_bits;
  logic        busy, tick_os, bit_start, bit_mid, frame_done;
  logic [3:0]  bit_idx;

  int tests = 0;
  int fails = 0;
  int nprint = 0;

  always #5 clk = ~clk;

  uart_baud_gen #(
    .CLK_FREQ     (200_000_000),
    .DEFAULT_BAUD (9600),
    .OVERSAMPLE   (16),
    .DIV_W        (16),
    .FRAC_W       (4),
    .MAX_BITS     (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_load     (cfg_load),
    .frame_bits   (frame_bits),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .tick_os      (tick_os),
    .bit_start    (bit_start),
    .bit_mid      (bit_mid),
    .bit_idx      (bit_idx),
    .frame_done   (frame_done)
  );

  // ---------------- behavioural model (state describes the current cycle)
  bit m_valid = 1'b0;
  bit m_run, m_pend, m_done, m_bs;
  int m_t, m_n, m_nbits, m_idx, m_D, m_F, m_dint, m_dfrac, m_pint, m_pfrac;

  function automatic int t_of(input int n);
    return n * m_D + ((n - 1) * m_F) / FRAC_DEN - 1;
  endfunction

  function automatic bit m_tick();
    return m_run && (m_t == t_of(m_n + 1));
  endfunction

  task automatic model_step();
    bit tk, last, bend;
    int fb;
    if (!rst_n) begin
      m_valid = 1'b1; m_run = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_bs = 1'b0;
      m_idx = 0; m_dint = RST_INT; m_dfrac = RST_FRAC;
      return;
    end
    if (!m_valid) return;
    tk   = m_tick();
    last = tk && (m_n + 1 == OS * m_nbits);
    bend = tk && ((m_n + 1) % OS == 0);
    m_done = 1'b0;
    m_bs   = 1'b0;
    fb     = int'(frame_bits);
    if (!m_run) begin
      if (cfg_load) begin
        m_dint  = int'(cfg_div_int);
        m_dfrac = int'(cfg_div_frac);
      end
      if (start && !abort && fb >= 1 && fb <= MAXB) begin
        m_run = 1'b1; m_t = 0; m_n = 0; m_nbits = fb; m_idx = 0; m_bs = 1'b1;
        m_D = (m_dint < 2) ? 2 : m_dint;
        m_F = FRAC_ON ? m_dfrac : 0;
      end
    end else begin
      if (cfg_load) begin
        m_pend  = 1'b1;
        m_pint  = int'(cfg_div_int);
        m_pfrac = int'(cfg_div_frac);
      end
      if (abort || last) begin
        m_run  = 1'b0;
        m_done = !abort;
        if (m_pend) begin
          m_dint  = m_pint;
          m_dfrac = m_pfrac;
        end
        m_pend = 1'b0;
      end else begin
        m_t++;
        if (tk) m_n++;
        if (bend) begin
          m_idx++;
          m_bs = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare
  initial begin
    logic [8:0] exp_v, got_v;
    bit et, em;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        et    = m_tick();
        em    = et && (m_n % OS == OS / 2 - 1);
        exp_v = {m_run, et, m_bs, em, 4'(m_idx), m_done};
        got_v = {busy, tick_os, bit_start, bit_mid, bit_idx, frame_done};
        tests++;
        if (got_v !== exp_v) begin
          fails++;
          if (nprint < 30) begin
            nprint++;
            $display("FAIL cycle_outputs t=%0t: {busy,tick,bstart,bmid,idx,done} got %b, expected %b",
                     $time, got_v, exp_v);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- directed frame runner
  int r_done, r_tick1, r_tick2, r_tick3, r_mid1, r_bs1, r_c0b, r_idle, r_strobes;
  logic [8:0] r_probe;

  task automatic run_frame(input int fb, input int window, input bit hold,
                           input int load_at, input int load_int, input int abort_at,
                           input int rst_at, input int probe_at);
    int nt;
    nt = 0;
    r_done = -1; r_tick1 = -1; r_tick2 = -1; r_tick3 = -1; r_mid1 = -1;
    r_bs1 = -1; r_c0b = -1; r_idle = -1; r_strobes = 0; r_probe = '1;
    @(negedge clk);
    frame_bits = 4'(fb);
    start      = 1'b1;
    for (int off = 0; off < window; off++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (tick_os) begin
        nt++;
        if (nt == 1) r_tick1 = off;
        if (nt == 2) r_tick2 = off;
        if (nt == 3) r_tick3 = off;
      end
      if (bit_mid && r_mid1 < 0) r_mid1 = off;
      if (bit_start && off > 0 && r_bs1 < 0) r_bs1 = off;
      if (bit_start && off > 0 && bit_idx == 4'd0 && r_c0b < 0) r_c0b = off;
      if (frame_done && r_done < 0) r_done = off;
      if (!busy && r_idle < 0) r_idle = off;
      if (r_idle >= 0 && off > r_idle && (tick_os || bit_start || bit_mid || frame_done))
        r_strobes++;
      if (off == probe_at) r_probe = {busy, tick_os, bit_start, bit_mid, bit_idx, frame_done};
      cfg_load = (off == load_at);
      if (off == load_at) cfg_div_int = 16'(load_int);
      abort = (off == abort_at);
      rst_n = (off != rst_at);
    end
    start = 1'b0; cfg_load = 1'b0; abort = 1'b0; rst_n = 1'b1;
  endtask

  task automatic load_cfg(input int di, input int df);
    @(negedge clk);
    cfg_div_int  = 16'(di);
    cfg_div_frac = 4'(df);
    cfg_load     = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // ---------------- stimulus
  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0; frame_bits = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({busy, tick_os, bit_start, bit_mid, bit_idx, frame_done}), 0);
    rst_n = 1'b1;

    // 1: plain divide by 4
    load_cfg(4, 0);
    run_frame(10, 660, 1'b0, -1, 0, -1, -1, -1);
    check("t1_first_tick", r_tick1, 3);
    check("t1_first_mid", r_mid1, 31);
    check("t1_bit1_start", r_bs1, 64);
    check("t1_frame_done", r_done, 640);

    // 2: fractional 4 + 8/16
    load_cfg(4, 8);
    run_frame(10, 740, 1'b0, -1, 0, -1, -1, -1);
    check("t2_tick2", r_tick2, 7);
    check("t2_tick3", r_tick3, FRAC_ON ? 12 : 11);
    check("t2_frame_done", r_done, FRAC_ON ? 719 : 640);

    // 3: abort mid-frame
    load_cfg(4, 0);
    run_frame(10, 700, 1'b0, -1, 0, 100, -1, -1);
    check("t3_idle_after_abort", r_idle, 101);
    check("t3_no_frame_done", r_done, -1);
    check("t3_no_strobes_after", r_strobes, 0);

    // 4: reload during a frame is deferred to frame end
    run_frame(10, 660, 1'b0, 10, 8, -1, -1, -1);
    check("t4_frame_done_old_div", r_done, 640);
    run_frame(10, 1300, 1'b0, -1, 0, -1, -1, -1);
    check("t4_first_tick_new_div", r_tick1, 7);
    check("t4_frame_done_new_div", r_done, 1280);

    // 5: clamped divisor, start held so frames run back to back
    load_cfg(1, 0);
    run_frame(10, 340, 1'b1, -1, 0, -1, -1, -1);
    check("t5_first_tick", r_tick1, 1);
    check("t5_tick2", r_tick2, 3);
    check("t5_frame_done", r_done, 320);
    check("t5_next_c0", r_c0b, 321);
    pulse_abort();

    // 6: one-cycle reset mid-frame, divisor returns to default
    load_cfg(4, 0);
    run_frame(10, 110, 1'b0, -1, 0, -1, 100, 101);
    check("t6_outputs_after_reset", int'(r_probe), 0);
    run_frame(1, 1320, 1'b0, -1, 0, -1, -1, -1);
    check("t6_first_tick_default", r_tick1, RST_INT - 1);
    pulse_abort();

    // randomized traffic
    load_cfg(3, 5);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 15) == 0);
      frame_bits = 4'($urandom_range(0, 15));
      abort      = ($urandom_range(0, 299) == 0) && !m_pend;
      cfg_load   = ($urandom_range(0, 39) == 0) && !abort;
      if (cfg_load) begin
        cfg_div_int  = 16'($urandom_range(0, 6));
        cfg_div_frac = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; cfg_load = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got still running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
